// File: rtl/phy_tx_arbiter.sv
// phy_tx_arbiter
// Two-client round-robin arbiter and link-gating sequencer in front of the
// PHY transmitter (clk_32f domain). Client traffic is held off until
// link_idle has been high for LOCK_CYCLES consecutive cycles. After that,
// one 32-bit word is granted per beat of BEAT_CYCLES cycles, and its bytes
// are presented on the four lanes for the whole beat.
//
// Ports:
//   clk_32f             sole clock, rising edge
//   rst                 synchronous active-high reset
//   link_idle           receiver idle/aligned indication
//   req_a/req_b         client requests, held until granted
//   data_a/data_b       client words; byte [7:0] goes to lane 0
//   gnt_a/gnt_b         one-cycle grant pulses, at the start of the beat
//   out0..out3          lane bytes to the PHY transmitter
//   valid_out0..3       lane valids (always equal)
//   link_up             high while the link is declared up
//   beats_sent          granted beats since reset, wraps at 16 bits
module phy_tx_arbiter #(
    parameter int LOCK_CYCLES = 8,
    parameter int BEAT_CYCLES = 32
) (
    input  logic        clk_32f,
    input  logic        rst,
    input  logic        link_idle,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [7:0]  out0,
    output logic [7:0]  out1,
    output logic [7:0]  out2,
    output logic [7:0]  out3,
    output logic        valid_out0,
    output logic        valid_out1,
    output logic        valid_out2,
    output logic        valid_out3,
    output logic        link_up,
    output logic [15:0] beats_sent
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int BW = $clog2(BEAT_CYCLES);

    typedef enum logic {SYNC, LINK_UP} state_t;

    state_t        state, state_d;
    logic [LW-1:0] lock_cnt, lock_d;
    logic [BW-1:0] beat_cnt, beat_d;
    logic          last_b, last_d;     // 1: B had the most recent grant
    logic          ga_q, ga_d, gb_q, gb_d;
    logic [31:0]   word_q, word_d;
    logic          valid_q, valid_d;
    logic [15:0]   beats_q, beats_d;
    logic          pick_a, pick_b;
    logic          arb_cycle;

    always_comb begin
        state_d   = state;
        lock_d    = lock_cnt;
        beat_d    = beat_cnt;
        last_d    = last_b;
        ga_d      = 1'b0;
        gb_d      = 1'b0;
        word_d    = word_q;
        valid_d   = valid_q;
        beats_d   = beats_q;
        pick_a    = 1'b0;
        pick_b    = 1'b0;
        arb_cycle = (beat_cnt == BW'(BEAT_CYCLES - 1));

        case (state)
            SYNC: begin
                word_d  = '0;
                valid_d = 1'b0;
                beat_d  = '0;
                if (link_idle) begin
                    if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                        state_d = LINK_UP;
                        lock_d  = '0;
                    end else begin
                        lock_d = lock_cnt + LW'(1);
                    end
                end else begin
                    lock_d = '0;
                end
            end
            LINK_UP: begin
                if (!link_idle) begin
                    // Link loss beats a coincident arbitration: no grant, no count.
                    state_d = SYNC;
                    lock_d  = '0;
                    beat_d  = '0;
                    word_d  = '0;
                    valid_d = 1'b0;
                end else begin
                    beat_d = arb_cycle ? '0 : beat_cnt + BW'(1);
                    if (arb_cycle) begin
                        // On contention the client that did not win last time goes.
                        pick_a = req_a && (!req_b || last_b);
                        pick_b = req_b && !pick_a;
                        if (pick_a) begin
                            ga_d    = 1'b1;
                            word_d  = data_a;
                            valid_d = 1'b1;
                            last_d  = 1'b0;
                            beats_d = beats_q + 16'd1;
                        end else if (pick_b) begin
                            gb_d    = 1'b1;
                            word_d  = data_b;
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                            beats_d = beats_q + 16'd1;
                        end else begin
                            word_d  = '0;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (rst) begin
            state    <= SYNC;
            lock_cnt <= '0;
            beat_cnt <= '0;
            last_b   <= 1'b1;
            ga_q     <= 1'b0;
            gb_q     <= 1'b0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            beats_q  <= '0;
        end else begin
            state    <= state_d;
            lock_cnt <= lock_d;
            beat_cnt <= beat_d;
            last_b   <= last_d;
            ga_q     <= ga_d;
            gb_q     <= gb_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            beats_q  <= beats_d;
        end
    end

    assign gnt_a      = ga_q;
    assign gnt_b      = gb_q;
    assign out0       = word_q[7:0];
    assign out1       = word_q[15:8];
    assign out2       = word_q[23:16];
    assign out3       = word_q[31:24];
    assign valid_out0 = valid_q;
    assign valid_out1 = valid_q;
    assign valid_out2 = valid_q;
    assign valid_out3 = valid_q;
    assign link_up    = (state == LINK_UP);
    assign beats_sent = beats_q;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Testbench for phy_tx_arbiter: directed scenarios with fixed expectations,
// then randomized traffic, link drops and resets, all checked every cycle
// against a cycle-count based reference model.
module tb_phy_tx_arbiter;
    localparam int LOCK = 8;
    localparam int BEAT = 32;

    logic        clk_32f = 1'b0;
    logic        rst = 1'b1;
    logic        link_idle = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [31:0] data_a = '0, data_b = '0;
    logic        gnt_a, gnt_b;
    logic [7:0]  out0, out1, out2, out3;
    logic        valid_out0, valid_out1, valid_out2, valid_out3;
    logic        link_up;
    logic [15:0] beats_sent;

    phy_tx_arbiter #(.LOCK_CYCLES(LOCK), .BEAT_CYCLES(BEAT)) dut (
        .clk_32f(clk_32f), .rst(rst), .link_idle(link_idle),
        .req_a(req_a), .req_b(req_b), .data_a(data_a), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .valid_out0(valid_out0), .valid_out1(valid_out1),
        .valid_out2(valid_out2), .valid_out3(valid_out3),
        .link_up(link_up), .beats_sent(beats_sent)
    );

    always #5 clk_32f = ~clk_32f;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: link state by run length of idle cycles, beat position
    // by a free-running count of cycles since link-up.
    bit          m_up = 0;
    int          m_run = 0;
    int          m_phase = 0;
    bit          m_last_b = 1;
    bit          m_ga = 0, m_gb = 0, m_valid = 0;
    logic [31:0] m_word = '0;
    logic [15:0] m_beats = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        int winner; // 0 none, 1 A, 2 B
        m_ga = 0;
        m_gb = 0;
        if (rst) begin
            m_up = 0; m_run = 0; m_phase = 0; m_last_b = 1;
            m_valid = 0; m_word = '0; m_beats = '0;
        end else if (!m_up) begin
            if (link_idle) begin
                m_run++;
                if (m_run == LOCK) begin
                    m_up = 1; m_run = 0; m_phase = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (!link_idle) begin
            m_up = 0; m_run = 0; m_valid = 0; m_word = '0;
        end else begin
            if (m_phase % BEAT == BEAT - 1) begin
                winner = 0;
                if (req_a && req_b) winner = m_last_b ? 1 : 2;
                else if (req_a)     winner = 1;
                else if (req_b)     winner = 2;
                if (winner != 0) begin
                    m_ga = (winner == 1);
                    m_gb = (winner == 2);
                    m_word = (winner == 1) ? data_a : data_b;
                    m_valid = 1;
                    m_last_b = (winner == 2);
                    m_beats++;
                end else begin
                    m_valid = 0;
                    m_word = '0;
                end
            end
            m_phase++;
        end
    endtask

    task automatic step();
        @(posedge clk_32f);
        model_step();
        #1;
        cyc++;
        chk("gnt", {gnt_a, gnt_b}, {m_ga, m_gb});
        chk("valid", {valid_out3, valid_out2, valid_out1, valid_out0}, {4{m_valid}});
        chk("lanes", {out3, out2, out1, out0}, m_word);
        chk("link_up", link_up, m_up);
        chk("beats", beats_sent, m_beats);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        rst = 1'b1;
        link_idle = 1'b1;
        step();
        step();
        chk("reset_outs", {gnt_a, gnt_b, valid_out0, valid_out1, valid_out2, valid_out3,
                           link_up, out0, out1, out2, out3, beats_sent}, 32'h0);
        rst = 1'b0;
        cyc = 0;

        // Lock restarts after a one-cycle dropout at cycle 5.
        run_to(5);
        link_idle = 1'b0;
        step();
        link_idle = 1'b1;
        run_to(13);
        chk("lock_early", link_up, 1'b0);
        step();
        chk("lock_up", link_up, 1'b1);

        // Single client: first arbitration 31 cycles after link-up.
        req_a = 1'b1;
        data_a = 32'hA1B2C3D4;
        run_to(45);
        chk("single_pre", {gnt_a, gnt_b, valid_out0}, 3'b000);
        step();
        chk("single_gnt", {gnt_a, gnt_b}, 2'b10);
        chk("single_lanes", {out3, out2, out1, out0}, 32'hA1B2C3D4);
        chk("single_valid", {valid_out3, valid_out2, valid_out1, valid_out0}, 4'hF);
        chk("single_beats", beats_sent, 16'd1);
        req_a = 1'b0;
        data_a = 32'h5555_5555;
        run_to(77);
        chk("hold_lanes", {out3, out2, out1, out0}, 32'hA1B2C3D4);
        chk("hold_valid", valid_out0, 1'b1);

        // Idle beat.
        step();
        chk("idle_valid", {valid_out3, valid_out2, valid_out1, valid_out0}, 4'h0);
        chk("idle_lanes", {out3, out2, out1, out0}, 32'h0);
        chk("idle_beats", beats_sent, 16'd1);

        // Round robin: A won last, so B goes first.
        req_a = 1'b1; req_b = 1'b1;
        data_a = $urandom; data_b = $urandom;
        for (int k = 0; k < 4; k++) begin
            run_to(109 + 32 * k);
            step();
            chk("rr_gnt", {gnt_a, gnt_b}, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_beats", beats_sent, 16'(2 + k));
            if (gnt_a) data_a = $urandom;
            if (gnt_b) data_b = $urandom;
        end
        req_a = 1'b0; req_b = 1'b0;

        // Link loss mid-beat with a pending B request.
        req_b = 1'b1;
        data_b = 32'hCAFE_0B0B;
        run_to(220);
        link_idle = 1'b0;
        step();
        chk("loss_out", {link_up, valid_out0, valid_out3, out0, out1, out2, out3}, 32'h0);
        link_idle = 1'b1;
        run_to(260);
        chk("loss_nognt", gnt_b, 1'b0);
        step();
        chk("loss_regnt", {gnt_a, gnt_b}, 2'b01);
        chk("loss_lanes", {out3, out2, out1, out0}, 32'hCAFE_0B0B);
        req_b = 1'b0;

        // Mid-operation reset; afterwards A must win the first tie.
        run_to(270);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_outs", {gnt_a, gnt_b, valid_out0, link_up, out0, out1, out2, out3, beats_sent},
            32'h0);
        req_a = 1'b1; req_b = 1'b1;
        data_a = $urandom; data_b = $urandom;
        run_to(310);
        step();
        chk("rst_tie", {gnt_a, gnt_b}, 2'b10);
        if (gnt_a) data_a = $urandom;

        // Random traffic with occasional link drops and resets.
        for (int i = 0; i < 20000; i++) begin
            rst = ($urandom_range(2999) == 0);
            link_idle = ($urandom_range(299) != 0);
            step();
            if (m_ga || !req_a) begin
                req_a = 1'($urandom_range(1));
                data_a = $urandom;
            end
            if (m_gb || !req_b) begin
                req_b = 1'($urandom_range(1));
                data_b = $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
